// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Holds BUSY while the divide runs so the hazard unit can stall the pipeline.
// Divide-by-zero and signed overflow are resolved in a single cycle.
//
// Ports:
//   CLK     - system clock, rising edge
//   RESET   - synchronous, active-high reset
//   START   - divide request, accepted only in IDLE
//   OP      - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   DATA1   - dividend (rs1), sampled on the accepting edge
//   DATA2   - divisor (rs2), sampled on the accepting edge
//   ABORT   - pipeline flush, cancels the in-flight operation
//   BUSY    - high whenever the sequencer is not IDLE
//   VALID   - one-cycle pulse, RESULT valid in that cycle
//   RESULT  - quotient or remainder, held until the next accepted START/RESET
module div_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [1:0]      OP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            ABORT,
  output logic            BUSY,
  output logic            VALID,
  output logic [XLEN-1:0] RESULT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            neg_q, neg_d;      // quotient must be negated
  logic            dsign_q, dsign_d;  // dividend sign, sets remainder sign
  logic [XLEN-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [XLEN-1:0] quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0] rem_q, rem_d;      // partial remainder
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand decode on the request side
  logic            signed_op;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, sgn_ovf;

  // One restoring-division step
  logic [XLEN:0]   rem_sh;
  logic            take;
  logic [XLEN-1:0] rem_nx, quo_nx;
  logic [XLEN-1:0] q_fix, r_fix;

  always_comb begin
    signed_op = ~OP[0];
    a_neg     = signed_op & DATA1[XLEN-1];
    b_neg     = signed_op & DATA2[XLEN-1];
    a_mag     = a_neg ? (~DATA1 + XLEN'(1)) : DATA1;
    b_mag     = b_neg ? (~DATA2 + XLEN'(1)) : DATA2;
    div_zero  = (DATA2 == '0);
    sgn_ovf   = signed_op && (DATA1 == MIN_NEG) && (DATA2 == '1);
  end

  // The trial subtraction is non-negative exactly when the shifted remainder
  // is at least the divisor; the difference then fits back into XLEN bits.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    take   = (rem_sh >= {1'b0, dvs_q});
    rem_nx = take ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], take};
    q_fix  = neg_q   ? (~quo_nx + XLEN'(1)) : quo_nx;
    r_fix  = dsign_q ? (~rem_nx + XLEN'(1)) : rem_nx;
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    dsign_d  = dsign_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          op_d    = OP;
          neg_d   = a_neg ^ b_neg;
          dsign_d = a_neg;
          dvs_d   = b_mag;
          quo_d   = a_mag;
          rem_d   = '0;
          cnt_d   = '0;
          if (div_zero) begin
            state_d  = S_DONE;
            result_d = OP[1] ? DATA1 : '1;
          end else if (sgn_ovf) begin
            state_d  = S_DONE;
            result_d = OP[1] ? '0 : MIN_NEG;
          end else begin
            state_d  = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (ABORT) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d  = S_DONE;
            result_d = op_q[1] ? (op_q[0] ? rem_nx : r_fix)
                               : (op_q[0] ? quo_nx : q_fix);
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      dsign_q  <= 1'b0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      dsign_q  <= dsign_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign BUSY   = (state_q != S_IDLE);
  assign VALID  = (state_q == S_DONE);
  assign RESULT = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: stimulus pushes expected result/cycle,
// a negedge monitor pops and compares on every VALID pulse.
module tb_div_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [1:0]  OP;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic        ABORT;
  logic        BUSY;
  logic        VALID;
  logic [31:0] RESULT;

  div_sequencer #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP),
    .DATA1(DATA1), .DATA2(DATA2), .ABORT(ABORT),
    .BUSY(BUSY), .VALID(VALID), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every VALID pulse must match the oldest outstanding expectation
  always @(negedge CLK) begin
    exp_t e;
    if (VALID === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid at cycle %0d: got VALID=1 RESULT=0x%08h expected no pulse",
                 cyc, RESULT);
      end else begin
        e = sb.pop_front();
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
        chk("result", RESULT, e.res);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int c0);
    c0    = cyc;
    START = 1'b1;
    OP    = op;
    DATA1 = a;
    DATA2 = b;
    tick();
    START = 1'b0;
  endtask

  task automatic push(input logic [31:0] res, input int at);
    exp_t e;
    e.res = res;
    e.cyc = at;
    sb.push_back(e);
  endtask

  // Check BUSY each cycle relative to start cycle c0 up to and including 'last'
  task automatic watch(input int c0, input int last, input int busy_end);
    while (cyc - c0 <= last) begin
      chk("busy", {31'd0, BUSY}, {31'd0, (cyc - c0 >= 1) && (cyc - c0 <= busy_end)});
      tick();
    end
  endtask

  logic [1:0]  sp_op  [4] = '{2'd1, 2'd3, 2'd0, 2'd2};
  logic [31:0] sp_a   [4] = '{32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] sp_b   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] sp_res [4] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0};

  initial begin
    int c;
    int c2;
    RESET = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    OP    = 2'd0;
    DATA1 = '0;
    DATA2 = '0;
    tick();
    tick();
    RESET = 1'b0;
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    chk("reset_valid", {31'd0, VALID}, 32'd0);
    chk("reset_result", RESULT, 32'd0);

    // DIV 20 / -3 = -6
    start_op(2'd0, 32'd20, 32'hFFFF_FFFD, c);
    push(32'hFFFF_FFFA, c + 33);
    watch(c, 34, 33);

    // REM -20 % 3 then REMU 0xFFFFFFEC % 3 at minimum spacing
    start_op(2'd2, 32'hFFFF_FFEC, 32'd3, c);
    push(32'hFFFF_FFFE, c + 33);
    watch(c, 33, 33);
    start_op(2'd3, 32'hFFFF_FFEC, 32'd3, c2);
    chk("min_spacing", 32'(c2 - c), 32'd34);
    push(32'd2, c2 + 33);
    watch(c2, 34, 33);

    // Divide-by-zero and signed overflow complete in one cycle
    for (int i = 0; i < 4; i++) begin
      start_op(sp_op[i], sp_a[i], sp_b[i], c);
      push(sp_res[i], c + 1);
      watch(c, 2, 1);
    end

    // START while busy is ignored
    start_op(2'd0, 32'd100, 32'd7, c);
    push(32'd14, c + 33);
    watch(c, 4, 33);
    START = 1'b1;
    OP    = 2'd1;
    DATA1 = 32'd55;
    DATA2 = 32'd5;
    tick();
    START = 1'b0;
    watch(c, 34, 33);

    // ABORT in cycle 10, new DIVU 9/2 in cycle 12
    start_op(2'd0, 32'd100, 32'd7, c);
    watch(c, 9, 33);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_result_held", RESULT, 32'd14);
    tick();
    start_op(2'd1, 32'd9, 32'd2, c2);
    chk("restart_cycle", 32'(c2 - c), 32'd12);
    push(32'd4, c2 + 33);
    watch(c2, 34, 33);

    // RESET mid-operation, START accepted in the first cycle after
    start_op(2'd0, 32'd1000, 32'd3, c);
    watch(c, 14, 33);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("midreset_busy", {31'd0, BUSY}, 32'd0);
    chk("midreset_valid", {31'd0, VALID}, 32'd0);
    chk("midreset_result", RESULT, 32'd0);
    start_op(2'd1, 32'd9, 32'd2, c2);
    push(32'd4, c2 + 33);
    watch(c2, 34, 33);

    // ABORT and START together in IDLE: START dropped
    ABORT = 1'b1;
    START = 1'b1;
    OP    = 2'd1;
    DATA1 = 32'd7;
    DATA2 = 32'd0;
    tick();
    ABORT = 1'b0;
    START = 1'b0;
    chk("abort_start_busy", {31'd0, BUSY}, 32'd0);
    tick();
    tick();
    chk("abort_start_result", RESULT, 32'd4);

    for (int i = 0; i < 100 && sb.size() > 0; i++) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle sequencer for the M-extension divide/remainder operations (DIV, DIVU, REM, REMU).
- Replaces the single-cycle combinational divide path in the EX stage with a radix-2 restoring divider.
- Raises BUSY so the hazard unit stalls the pipeline until the result is ready.
- Handles the RISC-V divide-by-zero and signed-overflow cases in one cycle.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request a divide; accepted only in IDLE.
- OP  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- DATA1  input  XLEN  dividend (rs1); sampled on the accepting edge only.
- DATA2  input  XLEN  divisor (rs2); sampled on the accepting edge only.
- ABORT  input  1  pipeline flush; cancels the in-flight operation.
- BUSY  output  1  high whenever state is not IDLE.
- VALID  output  1  one-cycle pulse; RESULT is valid in that cycle.
- RESULT  output  XLEN  quotient or remainder; holds its value until the next accepted START or RESET.

Behaviour:
- Reset: on an edge with RESET=1, state goes to IDLE and BUSY, VALID, RESULT and all internal registers go to 0. This applies regardless of the current state, including mid-operation. RESET has priority over ABORT and START.
- States: IDLE, CALC, DONE, encoded in a 2-bit register.
- IDLE, START=1: latch OP, the divisor sign, the dividend sign, |DATA1| and |DATA2| (absolute values only for signed ops), and clear the partial remainder and counter.
  - DATA2==0: next state DONE; quotient = all ones, remainder = DATA1 unmodified.
  - Signed op with DATA1==0x80000000 and DATA2==0xFFFFFFFF: next state DONE; quotient = 0x80000000, remainder = 0.
  - Otherwise: next state CALC.
- IDLE, START=0: remain in IDLE.
- CALC, one iteration per cycle:
  - Shift {rem,quo} left by 1 and bring in the dividend MSB.
  - Compute trial = rem - divisor on XLEN+1 bits.
  - If trial is non-negative, rem = trial and quo[0] = 1; otherwise quo[0] = 0.
  - Increment the counter; after XLEN iterations, go to DONE.
- Sign fix-up, signed ops: negate the quotient if the dividend and divisor signs differ; the remainder takes the dividend's sign. Unsigned ops use raw values.
- DONE: VALID=1 for exactly this cycle. RESULT = quotient for OP[1]=0, remainder for OP[1]=1. Next state IDLE.
- Latency, normal case: START in cycle 0 gives VALID in cycle XLEN+1 (cycle 33). BUSY is high in cycles 1..33.
- Latency, special cases: VALID and BUSY high in cycle 1 only.
- START while BUSY: ignored; operands are not re-sampled.
- Minimum spacing between accepted STARTs: XLEN+2 cycles. A START in the DONE cycle is ignored.
- ABORT=1 in CALC or DONE: next state IDLE, no VALID pulse, RESULT unchanged.
- ABORT in IDLE: no effect. If ABORT and START are both high in IDLE, ABORT wins and START is dropped.
- RESULT updates only on the edge entering DONE; it is stable at all other times.
- All arithmetic is unsigned on internal magnitudes; no X propagation from unused operand bits.

Test Plan:
- DIV, DATA1=20, DATA2=0xFFFFFFFD (-3), START in cycle 0 -> BUSY cycles 1..33; VALID in cycle 33 only; RESULT=0xFFFFFFFA (-6).
- REM -20 % 3, then REMU 0xFFFFFFEC % 3, back-to-back with minimum spacing -> RESULT 0xFFFFFFFE, then 0x00000002; exactly one VALID per operation.
- DIVU 7/0 -> VALID in cycle 1, RESULT=0xFFFFFFFF. REMU 7/0 -> RESULT=7. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. All complete in 1 cycle.
- DIV 100/7 started; in cycle 5 change DATA1/DATA2 and pulse START -> ignored; RESULT=14 in cycle 33.
- DIV 100/7 started; ABORT in cycle 10 -> BUSY low from cycle 11, no VALID, RESULT retains previous value. A new START in cycle 12 for DIVU 9/2 -> VALID in cycle 45, RESULT=4.
- DIV in progress; RESET in cycle 15 -> state IDLE and BUSY=VALID=RESULT=0 from cycle 16; START in cycle 16 is accepted normally.
